// File: rtl/accelerator_pkg.sv
// Shared types and helpers for the vector load/store unit.
package accelerator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    FINISH
  } vlsu_state_t;

  localparam logic [1:0] VSEW_8  = 2'd0;
  localparam logic [1:0] VSEW_16 = 2'd1;
  localparam logic [1:0] VSEW_32 = 2'd2;

  // log2 of bytes per element; the reserved encoding behaves as 32b
  function automatic logic [1:0] sew_shift(input logic [1:0] vsew);
    case (vsew)
      VSEW_8:  return 2'd0;
      VSEW_16: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Byte mask of the final register word: low bytes set, all four when full
  function automatic logic [3:0] last_word_mask(input logic [1:0] vl_lo, input logic [1:0] vsew);
    logic [1:0] nb;
    case (sew_shift(vsew))
      2'd0:    nb = vl_lo;
      2'd1:    nb = {vl_lo[0], 1'b0};
      default: nb = 2'b00;
    endcase
    case (nb)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/vlsu_lane_align.sv
// Extracts one element from its byte lane in a bus word and inserts it
// into the given slot of the assembly word.
module vlsu_lane_align
  import accelerator_pkg::*;
(
  input  logic [31:0] bus_word,
  input  logic [1:0]  vsew,
  input  logic [1:0]  lane_off,
  input  logic [1:0]  slot,
  input  logic [31:0] asm_in,
  output logic [31:0] asm_out
);

  logic [31:0] shifted;
  logic [31:0] elem;
  logic [31:0] mask;
  logic [4:0]  ins_sh;

  // Shift element down to bit 0, mask to width, merge into its slot
  always_comb begin
    shifted = bus_word >> {lane_off, 3'b000};
    case (vsew)
      VSEW_8: begin
        mask   = 32'h0000_00FF;
        ins_sh = {slot, 3'b000};
      end
      VSEW_16: begin
        mask   = 32'h0000_FFFF;
        ins_sh = {slot[0], 4'b0000};
      end
      default: begin
        mask   = '1;
        ins_sh = '0;
      end
    endcase
    elem    = shifted & mask;
    asm_out = (asm_in & ~(mask << ins_sh)) | (elem << ins_sh);
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: unit-stride loads/stores and strided loads over
// an OBI-style bus, one vector-register word per vlsu_ready_o pulse.
// Optional bus error tracking is enabled by defining VLSU_BUS_ERR_EN.
module vector_lsu
  import accelerator_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned VL_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vlsu_en_i,
  input  logic              vlsu_load_i,
  input  logic              vlsu_store_i,
  input  logic              vlsu_strided_i,
  output logic              vlsu_ready_o,
  input  logic [31:0]       base_addr_i,
  input  logic [31:0]       stride_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [1:0]        vsew_i,
  input  logic [31:0]       vreg_rdata_i,
  output logic [31:0]       vreg_wdata_o,
  output logic              vreg_we_o,
  output logic [3:0]        vreg_be_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
`ifdef VLSU_BUS_ERR_EN
  input  logic              data_err_i,
  output logic              vlsu_err_o,
`endif
  input  logic [31:0]       data_rdata_i
);

  vlsu_state_t state_q, state_n;

  logic [31:0]     cur_addr_q, stride_q, wdata_q, asm_q, asm_next;
  logic [VL_W-1:0] vl_q, elem_idx_q, words_q, word_idx_q, words_i;
  logic [1:0]      vsew_q, lane_off, slot;
  logic            load_q, strided_q, abort_q;
  logic [VL_W+1:0] nbytes, nbytes_up;
  logic            start, consume, last_elem, last_word, slot_last, word_done;
  logic [3:0]      elem_be, word_be;

  // Word count of a starting op, from the live inputs
  always_comb begin
    nbytes    = {2'b00, vl_i} << sew_shift(vsew_i);
    nbytes_up = nbytes + (VL_W+2)'(3);
    words_i   = nbytes_up[VL_W+1:2];
  end

  // Lane offset, slot position and byte enables of the current access
  always_comb begin
    case (vsew_q)
      VSEW_8: begin
        lane_off  = cur_addr_q[1:0];
        slot      = elem_idx_q[1:0];
        slot_last = (elem_idx_q[1:0] == 2'd3);
        elem_be   = 4'b0001 << cur_addr_q[1:0];
      end
      VSEW_16: begin
        lane_off  = {cur_addr_q[1], 1'b0};
        slot      = {1'b0, elem_idx_q[0]};
        slot_last = elem_idx_q[0];
        elem_be   = 4'b0011 << {cur_addr_q[1], 1'b0};
      end
      default: begin
        lane_off  = 2'b00;
        slot      = 2'b00;
        slot_last = 1'b1;
        elem_be   = 4'b1111;
      end
    endcase
    last_elem = (elem_idx_q == vl_q - VL_W'(1));
    last_word = strided_q ? last_elem : (word_idx_q == words_q - VL_W'(1));
    word_done = strided_q ? (slot_last || last_elem) : 1'b1;
    word_be   = last_word ? last_word_mask(vl_q[1:0], vsew_q) : 4'b1111;
  end

  vlsu_lane_align u_lane_align (
    .bus_word (data_rdata_i),
    .vsew     (vsew_q),
    .lane_off (lane_off),
    .slot     (slot),
    .asm_in   (asm_q),
    .asm_out  (asm_next)
  );

  // Next-state logic and completion strobes
  always_comb begin
    state_n      = state_q;
    start        = 1'b0;
    consume      = 1'b0;
    vlsu_ready_o = 1'b0;
    vreg_we_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (vlsu_en_i && (vlsu_load_i || vlsu_store_i)) begin
          start = 1'b1;
          if (vl_i == '0) begin
            vlsu_ready_o = 1'b1;
            state_n      = FINISH;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        // A granted request is still followed through to its response
        if (data_gnt_i)      state_n = RESP;
        else if (!vlsu_en_i) state_n = IDLE;
      end
      RESP: begin
        if (data_rvalid_i) begin
          if (abort_q || !vlsu_en_i) begin
            state_n = IDLE;
          end else begin
            consume = 1'b1;
            if (word_done) begin
              vlsu_ready_o = 1'b1;
              vreg_we_o    = load_q;
              state_n      = last_word ? FINISH : REQ;
            end else begin
              state_n = REQ;
            end
          end
        end
      end
      FINISH: begin
        if (!vlsu_en_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bus and vreg outputs, zero outside their active phases
  always_comb begin
    data_req_o   = (state_q == REQ);
    data_addr_o  = data_req_o ? {cur_addr_q[ADDR_W-1:2], 2'b00} : '0;
    data_we_o    = data_req_o && !load_q;
    data_be_o    = data_req_o ? (strided_q ? elem_be : word_be) : '0;
    data_wdata_o = data_we_o ? wdata_q : '0;
    vreg_wdata_o = vreg_we_o ? (strided_q ? asm_next : data_rdata_i) : '0;
    vreg_be_o    = vreg_we_o ? word_be : '0;
  end

  // State register, op context and progress counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      stride_q   <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      vl_q       <= '0;
      elem_idx_q <= '0;
      words_q    <= '0;
      word_idx_q <= '0;
      vsew_q     <= '0;
      load_q     <= 1'b0;
      strided_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      if (start) begin
        cur_addr_q <= base_addr_i;
        stride_q   <= stride_i;
        vl_q       <= vl_i;
        vsew_q     <= vsew_i;
        words_q    <= words_i;
        load_q     <= vlsu_load_i;
        strided_q  <= vlsu_strided_i && vlsu_load_i;
        elem_idx_q <= '0;
        word_idx_q <= '0;
        asm_q      <= '0;
        abort_q    <= 1'b0;
        wdata_q    <= vreg_rdata_i;
      end
      if (state_q == REQ && data_gnt_i)        abort_q <= !vlsu_en_i;
      else if (state_q == RESP && !vlsu_en_i)  abort_q <= 1'b1;
      if (consume) begin
        elem_idx_q <= elem_idx_q + VL_W'(1);
        cur_addr_q <= cur_addr_q + (strided_q ? stride_q : 32'd4);
        if (word_done) begin
          word_idx_q <= word_idx_q + VL_W'(1);
          asm_q      <= '0;
        end else begin
          asm_q <= asm_next;
        end
        if (state_n == REQ) wdata_q <= vreg_rdata_i;
      end
    end
  end

`ifdef VLSU_BUS_ERR_EN
  logic err_q;

  // Sticky error flag, cleared at op start
  always_ff @(posedge clk) begin
    if (reset)                                            err_q <= 1'b0;
    else if (start)                                       err_q <= 1'b0;
    else if (state_q == RESP && data_rvalid_i && data_err_i) err_q <= 1'b1;
  end

  assign vlsu_err_o = err_q;
`endif

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: reference model feeds expectation
// queues, a bus responder models the memory, a monitor checks outputs.
module tb_vector_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        vlsu_en_i, vlsu_load_i, vlsu_store_i, vlsu_strided_i;
  logic        vlsu_ready_o;
  logic [31:0] base_addr_i, stride_i;
  logic [4:0]  vl_i;
  logic [1:0]  vsew_i;
  logic [31:0] vreg_rdata_i, vreg_wdata_o;
  logic        vreg_we_o;
  logic [3:0]  vreg_be_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o, data_rdata_i;

  vector_lsu #(.ADDR_W(32), .VL_W(5)) dut (
    .clk(clk), .reset(reset),
    .vlsu_en_i(vlsu_en_i), .vlsu_load_i(vlsu_load_i), .vlsu_store_i(vlsu_store_i),
    .vlsu_strided_i(vlsu_strided_i), .vlsu_ready_o(vlsu_ready_o),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .vl_i(vl_i), .vsew_i(vsew_i),
    .vreg_rdata_i(vreg_rdata_i), .vreg_wdata_o(vreg_wdata_o), .vreg_we_o(vreg_we_o),
    .vreg_be_o(vreg_be_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} bus_t;
  typedef struct {logic we; logic chk; logic [3:0] be; logic [31:0] data;} rdy_t;

  bus_t        bus_q[$];
  rdy_t        rdy_q[$];
  int unsigned n_chk = 0, n_fail = 0, ready_seen = 0;
  int unsigned stall_cfg = 0, lat_cfg = 0;
  logic        const_mem = 1'b0;
  logic [31:0] st_src [16];
  logic [4:0]  st_word;

  assign vreg_rdata_i = st_src[st_word[3:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (const_mem) return 32'hDDCC_BBAA;
    return {addr[15:0], ~addr[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  // Memory responder: grant after stall_cfg cycles, rvalid lat_cfg cycles after entering RESP
  int unsigned stall_left = 0, lat_left = 0;
  logic        pending = 1'b0;
  logic [31:0] p_addr;
  always @(posedge clk) begin
    #2;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    if (reset) begin
      pending    = 1'b0;
      stall_left = stall_cfg;
      st_word    = '0;
    end else if (pending) begin
      if (lat_left == 0) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = mem_word(p_addr);
        pending       = 1'b0;
        st_word       = st_word + 5'd1;
      end else begin
        lat_left--;
      end
    end else if (data_req_o) begin
      if (stall_left == 0) begin
        data_gnt_i = 1'b1;
        pending    = 1'b1;
        p_addr     = data_addr_o;
        lat_left   = lat_cfg;
        stall_left = stall_cfg;
      end else begin
        stall_left--;
      end
    end else begin
      stall_left = stall_cfg;
      if (!vlsu_en_i) st_word = '0;
    end
  end

  // Monitor: compare bus requests and completions against the expectation queues
  always @(negedge clk) begin
    if (!reset) begin
      if (data_req_o) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("bus_addr", data_addr_o, bus_q[0].addr);
          chk("bus_be", {28'd0, data_be_o}, {28'd0, bus_q[0].be});
          chk("bus_we", {31'd0, data_we_o}, {31'd0, bus_q[0].we});
          chk("bus_wdata", data_wdata_o, bus_q[0].wdata);
          if (data_gnt_i) void'(bus_q.pop_front());
        end
      end
      if (vlsu_ready_o) begin
        ready_seen++;
        if (rdy_q.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          rdy_t r;
          r = rdy_q.pop_front();
          chk("vreg_we", {31'd0, vreg_we_o}, {31'd0, r.we});
          if (r.chk) begin
            chk("vreg_be", {28'd0, vreg_be_o}, {28'd0, r.be});
            chk("vreg_wdata", vreg_wdata_o, r.data);
          end
        end
      end else if (vreg_we_o) begin
        chk("vreg_we_without_ready", 32'd1, 32'd0);
      end
    end
  end

  // Build expectations from the access rules, then drive one op to completion
  task automatic run_op(input logic ld, input logic st, input logic sd,
                        input logic [31:0] base, input logic [31:0] stride,
                        input int vl, input logic [1:0] sew,
                        input int unsigned stall, input int unsigned lat);
    int eb, nb, nwords;
    int unsigned target;
    logic [7:0] vb [64];
    eb = 1 << sew;
    nb = vl * eb;
    nwords = (nb + 3) / 4;
    for (int i = 0; i < 16; i++) st_src[i] = $urandom;
    for (int i = 0; i < 64; i++) vb[i] = 8'h00;
    if (ld && sd) begin
      for (int e = 0; e < vl; e++) begin
        logic [31:0] a, al, w;
        int off;
        a   = base + stride * e;
        al  = a & 32'hFFFF_FFFC;
        off = int'(a[1:0]) & ~(eb - 1);
        bus_q.push_back('{al, 4'(((1 << eb) - 1) << off), 1'b0, 32'h0});
        w = mem_word(al);
        for (int k = 0; k < eb; k++) vb[e*eb + k] = 8'(w >> (8 * (off + k)));
      end
      for (int w = 0; w < nwords; w++) begin
        logic [3:0]  be;
        logic [31:0] d;
        be = '0; d = '0;
        for (int k = 0; k < 4; k++)
          if (4*w + k < nb) begin be[k] = 1'b1; d[8*k +: 8] = vb[4*w + k]; end
        rdy_q.push_back('{1'b1, 1'b1, be, d});
      end
    end else begin
      for (int w = 0; w < nwords; w++) begin
        logic [31:0] al;
        logic [3:0]  be;
        al = (base + 32'(4 * w)) & 32'hFFFF_FFFC;
        be = '0;
        for (int k = 0; k < 4; k++) if (4*w + k < nb) be[k] = 1'b1;
        bus_q.push_back('{al, be, !ld, ld ? 32'h0 : st_src[w]});
        rdy_q.push_back('{ld, ld, be, ld ? mem_word(al) : 32'h0});
      end
    end
    if (vl == 0) begin
      rdy_q.push_back('{1'b0, 1'b0, 4'h0, 32'h0});
      nwords = 1;
    end
    @(posedge clk); #1;
    target         = ready_seen + nwords;
    stall_cfg      = stall;
    lat_cfg        = lat;
    base_addr_i    = base;
    stride_i       = stride;
    vl_i           = 5'(vl);
    vsew_i         = sew;
    vlsu_load_i    = ld;
    vlsu_store_i   = st;
    vlsu_strided_i = sd;
    vlsu_en_i      = 1'b1;
    for (int c = 0; c < 3000 && ready_seen < target; c++) @(posedge clk);
    chk("ready_count", ready_seen, target);
    repeat (4) @(posedge clk);
    #1;
    vlsu_en_i    = 1'b0;
    vlsu_load_i  = 1'b0;
    vlsu_store_i = 1'b0;
    repeat (2) @(posedge clk);
    chk("bus_q_left", bus_q.size(), 0);
    chk("rdy_q_left", rdy_q.size(), 0);
    bus_q.delete();
    rdy_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_req"}, {31'd0, data_req_o}, 32'd0);
    chk({tag, "_ready"}, {31'd0, vlsu_ready_o}, 32'd0);
    chk({tag, "_vreg_we"}, {31'd0, vreg_we_o}, 32'd0);
    chk({tag, "_vreg_be"}, {28'd0, vreg_be_o}, 32'd0);
    chk({tag, "_vreg_wdata"}, vreg_wdata_o, 32'd0);
    chk({tag, "_addr"}, data_addr_o, 32'd0);
    chk({tag, "_be"}, {28'd0, data_be_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, data_we_o}, 32'd0);
    chk({tag, "_wdata"}, data_wdata_o, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    vlsu_en_i = 1'b0; vlsu_load_i = 1'b0; vlsu_store_i = 1'b0; vlsu_strided_i = 1'b0;
    base_addr_i = '0; stride_i = '0; vl_i = '0; vsew_i = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
    for (int i = 0; i < 16; i++) st_src[i] = '0;
    st_word = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 8, 2'd0, 0, 0);
    run_op(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 6, 2'd0, 1, 1);
    const_mem = 1'b1;
    run_op(1'b1, 1'b0, 1'b1, 32'h201, 32'd3, 4, 2'd0, 0, 0);
    const_mem = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 3, 2'd1, 3, 0);
    run_op(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 0, 2'd2, 0, 0);

    // Reset while a response is outstanding
    bus_q.push_back('{32'h400, 4'hF, 1'b0, 32'h0});
    rdy_q.push_back('{1'b1, 1'b1, 4'hF, mem_word(32'h400)});
    @(posedge clk); #1;
    stall_cfg = 0; lat_cfg = 3;
    base_addr_i = 32'h400; vl_i = 5'd8; vsew_i = 2'd0;
    vlsu_load_i = 1'b1; vlsu_strided_i = 1'b0; vlsu_en_i = 1'b1;
    for (int c = 0; c < 100 && bus_q.size() != 0; c++) @(posedge clk);
    chk("reset_test_grant", bus_q.size(), 0);
    #1;
    reset = 1'b1; vlsu_en_i = 1'b0; vlsu_load_i = 1'b0;
    @(posedge clk); #1;
    chk_outputs_zero("midop_reset");
    reset = 1'b0;
    rdy_q.delete();
    run_op(1'b1, 1'b0, 1'b0, 32'h440, 32'h0, 5, 2'd1, 1, 2);

    for (int n = 0; n < 25; n++) begin
      logic ld;
      ld = 1'($urandom);
      run_op(ld, !ld, 1'($urandom), $urandom, $urandom_range(0, 40) - 20,
             int'($urandom_range(0, 16)), 2'($urandom_range(0, 2)),
             $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_lsu.md
Name: vector_lsu

Overview:
Vector load/store unit. It sits directly downstream of the vector decoder and is driven by its vlsu_en/load/store/strided controls, using scalar_operand1 as the base address and scalar_operand2 as the stride.
- It moves one 32-bit vector-register word per vlsu_ready_o pulse between the vector register file and an OBI-style data bus.
- Supported modes: unit-stride loads, strided loads, and unit-stride stores.

Parameters:
ADDR_W, 32, data bus address width
VL_W, 5, width of vl (max vl 16)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
vlsu_en_i  in  1  operation active; held high by the decoder for the whole instruction
vlsu_load_i  in  1  load operation
vlsu_store_i  in  1  store operation
vlsu_strided_i  in  1  strided addressing (loads only)
vlsu_ready_o  out  1  one-cycle pulse: current register word completed
base_addr_i  in  32  base address, sampled at op start
stride_i  in  32  byte stride, sampled at op start
vl_i  in  VL_W  vector length, sampled at op start
vsew_i  in  2  element width: 0=8b, 1=16b, 2=32b
vreg_rdata_i  in  32  store data from the currently addressed vreg
vreg_wdata_o  out  32  load data to the vreg file
vreg_we_o  out  1  vreg write strobe
vreg_be_o  out  4  vreg byte enables
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  bus response valid
data_addr_o  out  ADDR_W  bus address
data_we_o  out  1  bus write
data_be_o  out  4  bus byte enables
data_wdata_o  out  32  bus write data
data_rdata_i  in  32  bus read data

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE:
    - An op starts when vlsu_en_i=1 and (load|store)=1.
    - On start, latch base, stride, vl, vsew, the mode bits, word_idx=0 and elem_idx=0.
    - vl=0 at start -> go to FINISH with one vlsu_ready_o pulse; no bus traffic, no vreg write.
    - Otherwise -> REQ.
  - REQ:
    - data_req_o=1.
    - addr, be, we and wdata are held stable until data_gnt_i.
    - On gnt -> RESP.
  - RESP:
    - Wait for data_rvalid_i (at least 1 cycle after gnt); exactly one transaction is outstanding.
    - When the word is complete: pulse vlsu_ready_o. For loads, also pulse vreg_we_o in the same cycle.
    - If the completed word is the last -> FINISH; else -> REQ for the next access.
  - FINISH: stay until vlsu_en_i=0, then -> IDLE. This guarantees no restart on a held enable.
- Element and word arithmetic:
  - bytes per element eb = 1<<vsew.
  - words = ceil(vl*eb/4).
  - Last word byte count = (vl*eb) mod 4, where 0 means full.
  - Last-word enable mask = low bytes set (1,2,3 bytes -> 0001, 0011, 0111).
- Unit-stride:
  - One access per word at address base + 4*word_idx.
  - data_addr_o[1:0] is forced to 00.
  - data_be_o is 1111, or the last-word mask on the final word; vreg_be_o is identical.
  - Loads: vreg_wdata_o = data_rdata_i.
  - Stores: data_we_o=1 and data_wdata_o = vreg_rdata_i, sampled on entry to REQ.
- Strided load:
  - One access per element at address base + stride*elem_idx (32-bit wrap, unaligned lanes allowed within a word).
  - data_addr_o[1:0] is forced to 00.
  - Lane offset: 8b uses addr[1:0]; 16b uses addr[1],0; 32b uses 0.
  - data_be_o covers the element's lanes.
  - The element is extracted from its lane and packed into word position elem_idx mod (4/eb) of an assembly register.
  - The word completes after 4/eb elements, or at element vl-1.
- vlsu_en_i falling mid-op: an outstanding transaction completes and is discarded (no write, no ready); a pending REQ is dropped only if not yet granted; the FSM returns to IDLE.
- Reset mid-op: immediate return to reset values, including data_req_o=0.
- vlsu_strided_i with a store: treated as unit-stride.

Optional Feature:
VLSU_BUS_ERR_EN
- With the macro: adds port data_err_i (in, 1, qualified by rvalid) and vlsu_err_o (out, 1).
  - An error response sets vlsu_err_o from the next cycle; it stays set until the next op start or reset.
  - The op otherwise proceeds unchanged.
- Without the macro: neither port exists and there is no error tracking.

Decomposition:
- accelerator_pkg gains:
  - vlsu_state_t (IDLE, REQ, RESP, FINISH)
  - VSEW_8/16/32 constants
  - a function returning the last-word byte mask from vl and vsew
- One combinational sub-module, vlsu_lane_align: element extract from a bus word and insert into the assembly word, given vsew, lane offset and slot index.

Test Plan:
- Unit load, vl=8, sew8, base 0x100, gnt the same cycle: accesses 0x100 then 0x104; two ready pulses; vreg_be 1111 both times; wdata equals bus data.
- Unit load, vl=6, sew8: second word has data_be and vreg_be 0011.
- Strided load, sew8, base 0x201, stride 3, vl=4, bus word holding 0xDDCCBBAA at each address:
  - addresses 0x200, 0x204, 0x204, 0x208
  - be 0010, 0001, 1000, 0100
  - one vreg write of 0xCCDDAABB
- Store, vl=3, sew16, gnt stalled 3 cycles:
  - addr, wdata and be stay stable during the stall
  - be 1111 then 0011
  - data_we_o=1
  - two ready pulses
- vl=0: one ready pulse, no data_req_o; a held vlsu_en_i does not restart the op.
- Reset asserted in RESP: next cycle all outputs 0 and the FSM is in IDLE; a new op then executes normally.
